// File: rtl/add_ctrl_pkg.sv
// Shared types and pin-index constants for the pin-level adder sequencer.
package add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    ADD    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit positions within uio_in / uio_out
  localparam int LOAD_BIT  = 0;
  localparam int ACK_BIT   = 1;
  localparam int CLR_BIT   = 2;
  localparam int BUSY_BIT  = 4;
  localparam int DONE_BIT  = 5;
  localparam int CARRY_BIT = 6;
  localparam int WAITB_BIT = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  typedef struct packed {
    logic wait_b;
    logic done;
    logic busy;
  } flags_t;

  // Moore status flags that belong to each state; loaded alongside the state
  function automatic flags_t flags_of(state_t s);
    flags_t f;
    f.wait_b = (s == WAIT_B);
    f.done   = (s == DONE);
    f.busy   = (s == WAIT_B) || (s == ADD);
    return f;
  endfunction

endpackage

// File: rtl/add_ctrl_sync_rise_det.sv
// Multi-flop input synchronizer with a registered previous-level flop for rise detection.
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tt_um_akanksha_hu8785_add_ctrl.sv
// Tiny Tapeout top: Moore sequencer capturing A then B and presenting A+B with carry.
// Optional MOORE_ACC_EN: a load in DONE chains a running sum instead of being ignored.
module tt_um_akanksha_hu8785_add_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  state_t      state_q;
  flags_t      flags_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [7:0]  out_q;
  logic        carry_q;

  logic load_level, load_rise;
  logic ack_level,  ack_rise;
  logic clr_level,  clr_rise;

  // Strobes are edge events with no back-pressure: a rise is consumed in the
  // cycle it appears whether or not the current state acts on it.
  sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uio_in[LOAD_BIT]),
    .level (load_level),
    .rise  (load_rise)
  );

  sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uio_in[ACK_BIT]),
    .level (ack_level),
    .rise  (ack_rise)
  );

  sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_clr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uio_in[CLR_BIT]),
    .level (clr_level),
    .rise  (clr_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flags_q <= flags_of(IDLE);
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      out_q   <= 8'h00;
      carry_q <= 1'b0;
    end else if (clr_level) begin
      state_q <= IDLE;
      flags_q <= flags_of(IDLE);
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      out_q   <= 8'h00;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_rise) begin
            a_q     <= ui_in;
            out_q   <= ui_in;
            state_q <= WAIT_B;
            flags_q <= flags_of(WAIT_B);
          end
        end
        WAIT_B: begin
          if (load_rise) begin
            b_q     <= ui_in;
            state_q <= ADD;
            flags_q <= flags_of(ADD);
          end
        end
        ADD: begin
          {carry_q, out_q} <= {1'b0, a_q} + {1'b0, b_q};
          state_q          <= DONE;
          flags_q          <= flags_of(DONE);
        end
        DONE: begin
          if (ack_rise) begin
            state_q <= IDLE;
            flags_q <= flags_of(IDLE);
          end
`ifdef MOORE_ACC_EN
          else if (load_rise) begin
            a_q     <= out_q;
            b_q     <= ui_in;
            state_q <= ADD;
            flags_q <= flags_of(ADD);
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          flags_q <= flags_of(IDLE);
        end
      endcase
    end
  end

  always_comb begin
    uio_out            = 8'h00;
    uio_out[BUSY_BIT]  = flags_q.busy;
    uio_out[DONE_BIT]  = flags_q.done;
    uio_out[CARRY_BIT] = carry_q;
    uio_out[WAITB_BIT] = flags_q.wait_b;
  end

  assign uo_out = out_q;
  assign uio_oe = UIO_OE_MASK;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:3], load_level, ack_level, clr_rise};

endmodule

// File: tb/tb_tt_um_akanksha_hu8785_add_ctrl.sv
// Directed bench for the adder sequencer: stimulus driven and checked on the falling edge.
module tb_tt_um_akanksha_hu8785_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_fail;

  tt_um_akanksha_hu8785_add_ctrl #(.SYNC_STAGES(2)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int idx, input logic [7:0] data);
    @(negedge clk);
    ui_in       = data;
    uio_in[idx] = 1'b1;
    @(negedge clk);
    uio_in[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    step(3);
    rst_n = 1'b1;
    step(5);
    n_checks++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo got=%h exp=%h", uo_out, 8'h00); end
    n_checks++;
    if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out got=%h exp=%h", uio_out, 8'h00); end
    n_checks++;
    if (uio_oe !== 8'hF0) begin n_fail++; $display("FAIL reset_uio_oe got=%h exp=%h", uio_oe, 8'hF0); end
  endtask

  task automatic test_add_basic();
    pulse(0, 8'h25);
    step(2);
    n_checks++;
    if (uo_out !== 8'h25) begin n_fail++; $display("FAIL basic_echo got=%h exp=%h", uo_out, 8'h25); end
    n_checks++;
    if (uio_out !== 8'h90) begin n_fail++; $display("FAIL basic_wait_b got=%h exp=%h", uio_out, 8'h90); end
    pulse(0, 8'h13);
    step(2);
    n_checks++;
    if (uio_out !== 8'h10) begin n_fail++; $display("FAIL basic_add_state got=%h exp=%h", uio_out, 8'h10); end
    step(1);
    n_checks++;
    if (uo_out !== 8'h38) begin n_fail++; $display("FAIL basic_sum got=%h exp=%h", uo_out, 8'h38); end
    n_checks++;
    if (uio_out !== 8'h20) begin n_fail++; $display("FAIL basic_done got=%h exp=%h", uio_out, 8'h20); end
    pulse(1, 8'h00);
    step(2);
    n_checks++;
    if (uo_out !== 8'h38) begin n_fail++; $display("FAIL basic_ack_hold got=%h exp=%h", uo_out, 8'h38); end
    n_checks++;
    if (uio_out !== 8'h00) begin n_fail++; $display("FAIL basic_ack_idle got=%h exp=%h", uio_out, 8'h00); end
  endtask

  task automatic test_add_carry();
    pulse(0, 8'hF0);
    step(2);
    pulse(0, 8'h20);
    step(3);
    n_checks++;
    if (uo_out !== 8'h10) begin n_fail++; $display("FAIL carry_sum got=%h exp=%h", uo_out, 8'h10); end
    n_checks++;
    if (uio_out !== 8'h60) begin n_fail++; $display("FAIL carry_flags got=%h exp=%h", uio_out, 8'h60); end
    pulse(1, 8'h00);
    step(2);
    n_checks++;
    if (uio_out !== 8'h40) begin n_fail++; $display("FAIL carry_idle_hold got=%h exp=%h", uio_out, 8'h40); end
  endtask

  task automatic test_clear();
    pulse(0, 8'h11);
    step(2);
    n_checks++;
    if (uio_out !== 8'hD0) begin n_fail++; $display("FAIL clear_pre got=%h exp=%h", uio_out, 8'hD0); end
    pulse(2, 8'h11);
    step(2);
    n_checks++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL clear_uo got=%h exp=%h", uo_out, 8'h00); end
    n_checks++;
    if (uio_out !== 8'h00) begin n_fail++; $display("FAIL clear_uio got=%h exp=%h", uio_out, 8'h00); end
    pulse(0, 8'h05);
    step(2);
    n_checks++;
    if (uo_out !== 8'h05) begin n_fail++; $display("FAIL clear_next_a got=%h exp=%h", uo_out, 8'h05); end
    n_checks++;
    if (uio_out !== 8'h90) begin n_fail++; $display("FAIL clear_next_wait got=%h exp=%h", uio_out, 8'h90); end
    pulse(0, 8'h01);
    step(3);
    n_checks++;
    if (uo_out !== 8'h06) begin n_fail++; $display("FAIL clear_next_sum got=%h exp=%h", uo_out, 8'h06); end
    pulse(1, 8'h00);
    step(2);
  endtask

  task automatic test_reset_mid_add();
    pulse(0, 8'h07);
    step(2);
    n_checks++;
    if (uo_out !== 8'h07) begin n_fail++; $display("FAIL rst_mid_echo got=%h exp=%h", uo_out, 8'h07); end
    pulse(0, 8'h08);
    step(2);
    n_checks++;
    if (uio_out !== 8'h10) begin n_fail++; $display("FAIL rst_mid_in_add got=%h exp=%h", uio_out, 8'h10); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_uo got=%h exp=%h", uo_out, 8'h00); end
    n_checks++;
    if (uio_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_uio got=%h exp=%h", uio_out, 8'h00); end
    n_checks++;
    if (uio_oe !== 8'hF0) begin n_fail++; $display("FAIL rst_mid_oe got=%h exp=%h", uio_oe, 8'hF0); end
    step(2);
    rst_n = 1'b1;
    step(2);
    pulse(0, 8'h01);
    step(2);
    pulse(0, 8'h02);
    step(3);
    n_checks++;
    if (uo_out !== 8'h03) begin n_fail++; $display("FAIL rst_mid_fresh_sum got=%h exp=%h", uo_out, 8'h03); end
    n_checks++;
    if (uio_out !== 8'h20) begin n_fail++; $display("FAIL rst_mid_fresh_done got=%h exp=%h", uio_out, 8'h20); end
    pulse(1, 8'h00);
    step(2);
  endtask

  task automatic test_done_load();
    pulse(0, 8'h10);
    step(2);
    pulse(0, 8'h20);
    step(3);
    n_checks++;
    if (uo_out !== 8'h30) begin n_fail++; $display("FAIL acc_first got=%h exp=%h", uo_out, 8'h30); end
    pulse(0, 8'h05);
    step(3);
`ifdef MOORE_ACC_EN
    n_checks++;
    if (uo_out !== 8'h35) begin n_fail++; $display("FAIL acc_chain1 got=%h exp=%h", uo_out, 8'h35); end
    n_checks++;
    if (uio_out !== 8'h20) begin n_fail++; $display("FAIL acc_chain1_flags got=%h exp=%h", uio_out, 8'h20); end
    pulse(0, 8'hD0);
    step(3);
    n_checks++;
    if (uo_out !== 8'h05) begin n_fail++; $display("FAIL acc_chain2 got=%h exp=%h", uo_out, 8'h05); end
    n_checks++;
    if (uio_out !== 8'h60) begin n_fail++; $display("FAIL acc_chain2_flags got=%h exp=%h", uio_out, 8'h60); end
`else
    n_checks++;
    if (uo_out !== 8'h30) begin n_fail++; $display("FAIL done_load_ignored got=%h exp=%h", uo_out, 8'h30); end
    n_checks++;
    if (uio_out !== 8'h20) begin n_fail++; $display("FAIL done_load_flags got=%h exp=%h", uio_out, 8'h20); end
`endif
  endtask

  task automatic test_ack_load_coincide();
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
`ifdef MOORE_ACC_EN
    exp_uo  = 8'h05;
    exp_uio = 8'h40;
`else
    exp_uo  = 8'h30;
    exp_uio = 8'h00;
`endif
    @(negedge clk);
    ui_in  = 8'h77;
    uio_in = 8'h03;
    @(negedge clk);
    uio_in = 8'h00;
    step(2);
    n_checks++;
    if (uio_out !== exp_uio) begin n_fail++; $display("FAIL coincide_idle got=%h exp=%h", uio_out, exp_uio); end
    n_checks++;
    if (uo_out !== exp_uo) begin n_fail++; $display("FAIL coincide_hold got=%h exp=%h", uo_out, exp_uo); end
    pulse(1, 8'h00);
    step(3);
    n_checks++;
    if (uio_out !== exp_uio) begin n_fail++; $display("FAIL ack_in_idle got=%h exp=%h", uio_out, exp_uio); end
  endtask

  task automatic test_reset_held_load();
    @(negedge clk);
    rst_n  = 1'b0;
    ui_in  = 8'h44;
    uio_in = 8'h01;
    step(2);
    rst_n = 1'b1;
    step(3);
    n_checks++;
    if (uo_out !== 8'h44) begin n_fail++; $display("FAIL held_load_echo got=%h exp=%h", uo_out, 8'h44); end
    n_checks++;
    if (uio_out !== 8'h90) begin n_fail++; $display("FAIL held_load_wait got=%h exp=%h", uio_out, 8'h90); end
    step(4);
    n_checks++;
    if (uio_out !== 8'h90) begin n_fail++; $display("FAIL held_load_single got=%h exp=%h", uio_out, 8'h90); end
    uio_in = 8'h00;
    step(2);
    pulse(2, 8'h00);
    step(2);
    n_checks++;
    if (uio_out !== 8'h00) begin n_fail++; $display("FAIL held_load_clear got=%h exp=%h", uio_out, 8'h00); end
  endtask

  // Sequence and final report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add_basic();
    test_add_carry();
    test_clear();
    test_reset_mid_add();
    test_done_load();
    test_ack_load_coincide();
    test_reset_held_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_akanksha_hu8785_add_ctrl.md
# tt_um_akanksha_hu8785_add_ctrl

Moore-style sequencer for the 8-bit pin-level adder datapath (uo_out = operand A + operand B). Operands arrive one at a time on `ui_in`, qualified by a load strobe on `uio_in`. The block captures A, then B, performs one registered add, and holds the sum and carry until acknowledged. It is the top-level Tiny Tapeout user module: all pins are driven from state registers, so outputs never depend combinationally on inputs.

## Interface
- `SYNC_STAGES`, default 2: flop depth of each input synchronizer; legal range is 2–3.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: ignored (tied into an unused-signal reduction).
- `ui_in` in 8: operand data.
- `uio_in` in 8: bit [0] `load` strobe, bit [1] `ack`, bit [2] `clear`; bits [7:3] ignored.
- `uo_out` out 8: result register (`out_q`).
- `uio_out` out 8: bit [4] `busy`, bit [5] `done`, bit [6] `carry`, bit [7] `wait_b`; bits [3:0] = 0.
- `uio_oe` out 8: constant 8'hF0.

## Operation
- Each of `load`, `ack` and `clear` passes through a SYNC_STAGES synchronizer followed by a `prev` flop.
- `load` and `ack` act on rising edges only (`sync & ~prev`). `clear` acts on the synchronized level.
- States:
  - IDLE: on `load` rise, capture A_q and `out_q` ← ui_in (echo of A), then go to WAIT_B.
  - WAIT_B: on `load` rise, capture B_q, then go to ADD.
  - ADD: takes exactly one cycle. {carry_q, out_q} ← A_q + B_q as a 9-bit sum; sum wraps mod 256 and carry_q gets bit 8. Then go to DONE.
  - DONE: on `ack` rise, go to IDLE. `out_q` and carry_q are held and stay on the pins in IDLE.
- Moore outputs:
  - `busy` = state ∈ {WAIT_B, ADD}
  - `done` = state == DONE
  - `wait_b` = state == WAIT_B
  - `carry` = carry_q
- Priority rules:
  - `clear` beats every other input in every state: go to IDLE and zero A_q, B_q, out_q and carry_q.
  - `ack` is ignored outside DONE.
  - `load` is ignored in ADD, and in DONE when the accumulate macro is not defined.
  - In DONE, if `ack` rise and `load` rise coincide, `ack` wins.
- Reset (asynchronous, including mid-operation): state = IDLE; A_q, B_q, out_q, carry_q, and all synchronizer and `prev` flops = 0.
  - Consequence: a `load` pin held high across reset release produces one rise.
- Outputs after reset: uo_out = 0x00, uio_out = 0x00, uio_oe = 0xF0.

## Timing
- A pin edge is first sampled at clock edge k. The synchronized rise is asserted after edge k+SYNC_STAGES−1, and the FSM acts on it at edge k+SYNC_STAGES.
- With SYNC_STAGES=2:
  - Operand is captured at edge k+2.
  - `done` and the sum are visible after edge k+3 for the B strobe.
- `ui_in` must be stable from the `load` pin edge through the capture edge.
- Strobe pulses must be high for at least 1 cycle and low for at least 1 cycle between events. Shorter pulses may be missed.
- `clear` takes effect SYNC_STAGES edges after its pin edge.

## Configuration
- Macro `MOORE_ACC_EN`.
  - Defined: in DONE, a `load` rise (without a coincident `ack` rise) sets A_q ← out_q and B_q ← ui_in, then goes to ADD. This chains a running sum. carry_q reflects only the latest add.
  - Not defined: `load` in DONE is ignored, and only `ack` leaves DONE.

## Structure
- Package `add_ctrl_pkg`:
  - `state_t`, 2-bit enum: IDLE=0, WAIT_B=1, ADD=2, DONE=3.
  - Index constants for the `uio` bit positions: LOAD=0, ACK=1, CLR=2, BUSY=4, DONE=5, CARRY=6, WAITB=7.
  - Constant `UIO_OE_MASK` = 8'hF0.
- Sub-module `sync_rise_det` (parameter SYNC_STAGES; ports clk, rst_n, d, level, rise). Instantiated three times, once each for `load`, `ack` and `clear`.

## Test plan
- Reset, then idle 5 cycles → uo_out=0x00, uio_out=0x00, uio_oe=0xF0.
- Load 0x25, then load 0x13:
  - `wait_b`=1 with uo_out=0x25 between the two loads.
  - Then `done`=1, uo_out=0x38, `carry`=0, 3 cycles after the B pin edge.
  - An `ack` pulse then returns to IDLE with 0x38 still held.
- Load 0xF0, then load 0x20 → uo_out=0x10, `carry`=1, `done`=1.
- Load 0x11, then assert `clear` in WAIT_B → IDLE, uo_out=0x00, `busy`=0. A following `load` 0x05 is treated as operand A.
- Drop `rst_n` in the cycle the FSM is in ADD → all outputs 0 immediately (asynchronous). After release, a fresh A/B sequence 0x01 + 0x02 gives 0x03.
- With `MOORE_ACC_EN`:
  - 0x10 + 0x20 → DONE with 0x30.
  - `load` 0x05 → 0x35.
  - `load` 0xD0 → 0x05 with `carry`=1.
  - Without the macro, the same `load` in DONE leaves uo_out at 0x30 and `done`=1.
